// File: rtl/refresh_sequencer.sv
// refresh_sequencer: snapshot bank state, precharge open banks, REF.
// Define REFRESH_REOPEN_EN to re-activate snapshot-open rows afterwards.
module refresh_sequencer #(
  parameter int ROW_WIDTH  = 16,
  parameter int BANK_WIDTH = 3,
  parameter int CS_WIDTH   = 1,
  parameter int T_RP       = 4,
  parameter int T_RFC      = 64,
  parameter int T_RCD      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ref_req_i,
  output logic                  ref_ack_o,
  output logic                  mnt_active_o,
  output logic [BANK_WIDTH-1:0] maint_bank_o,
  input  logic [ROW_WIDTH:0]    maint_bank_state_i,
  output logic [31:0]           mnt_instr_o,
  output logic                  mnt_valid_o,
  input  logic                  mnt_ready_i
);

  localparam int NUM_BANKS  = 1 << BANK_WIDTH;
  localparam int CS_OFFSET  = ROW_WIDTH + BANK_WIDTH;
  localparam int WE_OFFSET  = CS_OFFSET + CS_WIDTH;
  localparam int CAS_OFFSET = WE_OFFSET + 1;
  localparam int RAS_OFFSET = WE_OFFSET + 2;

  // {RAS, CAS, WE}
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_REF = 3'b001;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SCAN,
    S_PRE,
    S_WRP,
    S_REF,
    S_WRFC,
`ifdef REFRESH_REOPEN_EN
    S_ACT,
    S_WRCD,
`endif
    S_DONE
  } state_e;

  typedef logic [BANK_WIDTH-1:0] bank_t;
  typedef logic [NUM_BANKS-1:0]  mask_t;

  function automatic logic [31:0] mk(
    input logic [2:0]           rcw,
    input bank_t                b,
    input logic [ROW_WIDTH-1:0] r
  );
    logic [31:0] i;
    i = '0;
    i[31] = 1'b1;
    i[RAS_OFFSET] = rcw[2];
    i[CAS_OFFSET] = rcw[1];
    i[WE_OFFSET] = rcw[0];
    i[ROW_WIDTH +: BANK_WIDTH] = b;
    i[ROW_WIDTH-1:0] = r;
    return i;
  endfunction

  function automatic bank_t first_set(input mask_t m);
    bank_t f;
    f = '0;
    for (int i = NUM_BANKS - 1; i >= 0; i--)
      if (m[i]) f = bank_t'(i);
    return f;
  endfunction

  state_e      st_q;
  logic        pend_q;
  mask_t       open_q;
  mask_t       work_q;
  bank_t       bank_q;
  bank_t       cur_q;
  logic [7:0]  wait_q;
  logic        ack_q;
  logic        active_q;
  logic        valid_q;
  logic [31:0] instr_q;

  mask_t open_nx;
  mask_t rem;
  bank_t first_nx;
  bank_t first_rem;

`ifdef REFRESH_REOPEN_EN
  logic [ROW_WIDTH-1:0] rows_q [NUM_BANKS];
  bank_t                first_open;
`else
  logic unused_ok;
  assign unused_ok = ^{maint_bank_state_i[ROW_WIDTH-1:0], 8'(T_RCD)};
`endif

  // Open mask including this cycle's scan sample, and pending work.
  always_comb begin
    open_nx = open_q;
    open_nx[bank_q] = maint_bank_state_i[ROW_WIDTH];
    rem = work_q;
    rem[cur_q] = 1'b0;
    first_nx = first_set(open_nx);
    first_rem = first_set(rem);
`ifdef REFRESH_REOPEN_EN
    first_open = first_set(open_q);
`endif
  end

`ifdef REFRESH_REOPEN_EN
  // Row snapshot used to reopen banks after refresh.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_BANKS; i++) rows_q[i] <= '0;
    end else if (st_q == S_SCAN) begin
      rows_q[bank_q] <= maint_bank_state_i[ROW_WIDTH-1:0];
    end
  end
`endif

  // Sequencer FSM with registered command/handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= S_IDLE;
      pend_q   <= 1'b0;
      open_q   <= '0;
      work_q   <= '0;
      bank_q   <= '0;
      cur_q    <= '0;
      wait_q   <= '0;
      ack_q    <= 1'b0;
      active_q <= 1'b0;
      valid_q  <= 1'b0;
      instr_q  <= '0;
    end else begin
      ack_q <= 1'b0;
      if (st_q != S_IDLE && ref_req_i) pend_q <= 1'b1;
      unique case (st_q)
        S_IDLE: begin
          if (ref_req_i || pend_q) begin
            pend_q   <= 1'b0;
            st_q     <= S_SCAN;
            active_q <= 1'b1;
            bank_q   <= '0;
            open_q   <= '0;
          end
        end
        S_SCAN: begin
          open_q <= open_nx;
          if (bank_q == bank_t'(NUM_BANKS - 1)) begin
            bank_q  <= '0;
            valid_q <= 1'b1;
            if (|open_nx) begin
              st_q    <= S_PRE;
              work_q  <= open_nx;
              cur_q   <= first_nx;
              instr_q <= mk(C_PRE, first_nx, '0);
            end else begin
              st_q    <= S_REF;
              instr_q <= mk(C_REF, '0, '0);
            end
          end else begin
            bank_q <= bank_q + bank_t'(1);
          end
        end
        S_PRE: begin
          if (mnt_ready_i) begin
            work_q <= rem;
            if (|rem) begin
              cur_q   <= first_rem;
              instr_q <= mk(C_PRE, first_rem, '0);
            end else begin
              valid_q <= 1'b0;
              wait_q  <= 8'(T_RP);
              st_q    <= S_WRP;
            end
          end
        end
        S_WRP: begin
          wait_q <= wait_q - 8'd1;
          if (wait_q <= 8'd1) begin
            st_q    <= S_REF;
            valid_q <= 1'b1;
            instr_q <= mk(C_REF, '0, '0);
          end
        end
        S_REF: begin
          if (mnt_ready_i) begin
            valid_q <= 1'b0;
            wait_q  <= 8'(T_RFC);
            st_q    <= S_WRFC;
          end
        end
        S_WRFC: begin
          wait_q <= wait_q - 8'd1;
          if (wait_q <= 8'd1) begin
`ifdef REFRESH_REOPEN_EN
            if (|open_q) begin
              st_q    <= S_ACT;
              valid_q <= 1'b1;
              work_q  <= open_q;
              cur_q   <= first_open;
              instr_q <= mk(C_ACT, first_open, rows_q[first_open]);
            end else begin
              st_q  <= S_DONE;
              ack_q <= 1'b1;
            end
`else
            st_q  <= S_DONE;
            ack_q <= 1'b1;
`endif
          end
        end
`ifdef REFRESH_REOPEN_EN
        S_ACT: begin
          if (mnt_ready_i) begin
            work_q <= rem;
            if (|rem) begin
              cur_q   <= first_rem;
              instr_q <= mk(C_ACT, first_rem, rows_q[first_rem]);
            end else begin
              valid_q <= 1'b0;
              wait_q  <= 8'(T_RCD);
              st_q    <= S_WRCD;
            end
          end
        end
        S_WRCD: begin
          wait_q <= wait_q - 8'd1;
          if (wait_q <= 8'd1) begin
            st_q  <= S_DONE;
            ack_q <= 1'b1;
          end
        end
`endif
        S_DONE: begin
          st_q     <= S_IDLE;
          active_q <= 1'b0;
        end
        default: begin
          st_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ref_ack_o    = ack_q;
  assign mnt_active_o = active_q;
  assign maint_bank_o = bank_q;
  assign mnt_instr_o  = instr_q;
  assign mnt_valid_o  = valid_q;

endmodule

// File: tb/tb_refresh_sequencer.sv
// tb_refresh_sequencer: directed checks of the refresh sequencer.
// Expected cycles are hand-derived from the sequence timing.
module tb_refresh_sequencer;

  localparam int RW = 16;
  localparam int BW = 3;

  localparam logic [31:0] REF_I  = 32'h8010_0000;
  localparam logic [31:0] PRE_B2 = 32'h8022_0000;
  localparam logic [31:0] PRE_B5 = 32'h8025_0000;
  localparam logic [31:0] ACT_B2 = 32'h8032_1234;
  localparam logic [31:0] ACT_B5 = 32'h8035_0042;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ref_req = 1'b0;
  logic          mnt_ready = 1'b1;
  logic          ref_ack;
  logic          mnt_active;
  logic          mnt_valid;
  logic [BW-1:0] maint_bank;
  logic [RW:0]   maint_bank_state;
  logic [31:0]   mnt_instr;

  logic          bopen [8];
  logic [RW-1:0] brow  [8];

  int cyc = 0;
  int ncmp = 0;
  int nerr = 0;
  int s;

  logic [31:0] xq [$];
  int          xc [$];
  int          ackc [$];

  refresh_sequencer dut (
    .clk                (clk),
    .rst                (rst),
    .ref_req_i          (ref_req),
    .ref_ack_o          (ref_ack),
    .mnt_active_o       (mnt_active),
    .maint_bank_o       (maint_bank),
    .maint_bank_state_i (maint_bank_state),
    .mnt_instr_o        (mnt_instr),
    .mnt_valid_o        (mnt_valid),
    .mnt_ready_i        (mnt_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign maint_bank_state = {bopen[maint_bank], brow[maint_bank]};

  always @(negedge clk) begin
    if (mnt_valid && mnt_ready) begin
      xq.push_back(mnt_instr);
      xc.push_back(cyc);
    end
    if (ref_ack) ackc.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic goto(input int k);
    while (cyc < k) nc(1);
  endtask

  function automatic logic [31:0] gx(input int i);
    return (xq.size() > i) ? xq[i] : 32'hdead_beef;
  endfunction

  function automatic logic [31:0] gc(input int i);
    return (xc.size() > i) ? xc[i] : 32'hffff_ffff;
  endfunction

  function automatic logic [31:0] ga(input int i);
    return (ackc.size() > i) ? ackc[i] : 32'hffff_ffff;
  endfunction

  task automatic clr();
    xq.delete();
    xc.delete();
    ackc.delete();
  endtask

  task automatic start();
    ref_req = 1'b1;
    nc(1);
    ref_req = 1'b0;
    s = cyc;
  endtask

  task automatic pulse();
    ref_req = 1'b1;
    nc(1);
    ref_req = 1'b0;
  endtask

  task automatic wait_ack(input int n, input int lim);
    while (ackc.size() < n && cyc < lim) nc(1);
    chk("ack_seen", 32'(ackc.size() >= n), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      bopen[i] = 1'b0;
      brow[i] = 16'h0;
    end
    nc(3);
    chk("rst_ack", 32'(ref_ack), 32'd0);
    chk("rst_active", 32'(mnt_active), 32'd0);
    chk("rst_valid", 32'(mnt_valid), 32'd0);
    chk("rst_instr", mnt_instr, 32'h0);
    chk("rst_bank", 32'(maint_bank), 32'd0);
    rst = 1'b0;
    nc(2);

    // all banks closed: single REF
    clr();
    start();
    chk("t1_active", 32'(mnt_active), 32'd1);
    goto(s + 3);
    chk("t1_scanbank", 32'(maint_bank), 32'd3);
    wait_ack(1, s + 200);
    chk("t1_nx", 32'(xq.size()), 32'd1);
    chk("t1_ref", gx(0), REF_I);
    chk("t1_refcyc", gc(0), 32'(s + 8));
    chk("t1_ackcyc", ga(0), 32'(s + 73));
    goto(s + 74);
    chk("t1_ackpulse", 32'(ref_ack), 32'd0);
    chk("t1_actfall", 32'(mnt_active), 32'd0);
    nc(5);

    // banks 2 and 5 open
    bopen[2] = 1'b1;
    brow[2] = 16'h1234;
    bopen[5] = 1'b1;
    brow[5] = 16'h0042;
    clr();
    start();
    wait_ack(1, s + 200);
    chk("t2_pre2", gx(0), PRE_B2);
    chk("t2_pre2cyc", gc(0), 32'(s + 8));
    chk("t2_pre5", gx(1), PRE_B5);
    chk("t2_pre5cyc", gc(1), 32'(s + 9));
    chk("t2_ref", gx(2), REF_I);
    chk("t2_refcyc", gc(2), 32'(s + 14));
`ifdef REFRESH_REOPEN_EN
    chk("t2_nx", 32'(xq.size()), 32'd5);
    chk("t2_act2", gx(3), ACT_B2);
    chk("t2_act2cyc", gc(3), 32'(s + 79));
    chk("t2_act5", gx(4), ACT_B5);
    chk("t2_act5cyc", gc(4), 32'(s + 80));
    chk("t2_ackcyc", ga(0), 32'(s + 85));
`else
    chk("t2_nx", 32'(xq.size()), 32'd3);
    chk("t2_ackcyc", ga(0), 32'(s + 79));
`endif
    nc(5);

    // PRE b2 stalled 10 cycles
    mnt_ready = 1'b0;
    clr();
    start();
    goto(s + 8);
    chk("t3_valid0", 32'(mnt_valid), 32'd1);
    chk("t3_instr0", mnt_instr, PRE_B2);
    goto(s + 17);
    chk("t3_valid9", 32'(mnt_valid), 32'd1);
    chk("t3_instr9", mnt_instr, PRE_B2);
    goto(s + 18);
    mnt_ready = 1'b1;
    wait_ack(1, s + 250);
    chk("t3_pre2", gx(0), PRE_B2);
    chk("t3_pre2cyc", gc(0), 32'(s + 18));
    chk("t3_pre5", gx(1), PRE_B5);
    chk("t3_refcyc", gc(2), 32'(s + 24));
`ifdef REFRESH_REOPEN_EN
    chk("t3_nx", 32'(xq.size()), 32'd5);
    chk("t3_ackcyc", ga(0), 32'(s + 95));
`else
    chk("t3_nx", 32'(xq.size()), 32'd3);
    chk("t3_ackcyc", ga(0), 32'(s + 89));
`endif
    nc(5);
    bopen[2] = 1'b0;
    bopen[5] = 1'b0;

    // three requests during WAIT_RFC coalesce
    clr();
    start();
    goto(s + 20);
    pulse();
    goto(s + 30);
    pulse();
    goto(s + 40);
    pulse();
    goto(s + 74);
    chk("t4_idle_act", 32'(mnt_active), 32'd0);
    goto(s + 75);
    chk("t4_rescan", 32'(mnt_active), 32'd1);
    wait_ack(2, s + 300);
    chk("t4_ack0", ga(0), 32'(s + 73));
    chk("t4_ack1", ga(1), 32'(s + 148));
    goto(s + 240);
    chk("t4_nack", 32'(ackc.size()), 32'd2);
    chk("t4_nx", 32'(xq.size()), 32'd2);

    // reset during WAIT_RFC
    clr();
    start();
    goto(s + 20);
    pulse();
    goto(s + 30);
    rst = 1'b1;
    nc(1);
    chk("t5_valid", 32'(mnt_valid), 32'd0);
    chk("t5_active", 32'(mnt_active), 32'd0);
    chk("t5_ack", 32'(ref_ack), 32'd0);
    rst = 1'b0;
    nc(100);
    chk("t5_noack", 32'(ackc.size()), 32'd0);
    chk("t5_idle", 32'(mnt_active), 32'd0);
    clr();
    start();
    wait_ack(1, s + 200);
    chk("t5_ackcyc", ga(0), 32'(s + 73));
    chk("t5_nx", 32'(xq.size()), 32'd1);
    chk("t5_ref", gx(0), REF_I);
    nc(5);

    // ref_req held high
    clr();
    ref_req = 1'b1;
    nc(1);
    s = cyc;
    goto(s + 74);
    chk("t6_gap_act", 32'(mnt_active), 32'd0);
    chk("t6_gap_ack", 32'(ref_ack), 32'd0);
    nc(1);
    chk("t6_rescan", 32'(mnt_active), 32'd1);
    ref_req = 1'b0;
    wait_ack(2, s + 300);
    chk("t6_ack0", ga(0), 32'(s + 73));
    chk("t6_ack1", ga(1), 32'(s + 148));
    goto(s + 240);
    chk("t6_nack", 32'(ackc.size()), 32'd2);
    chk("t6_end", 32'(mnt_active), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
